// File: rtl/ps2_mouse_packet.sv
// ---------------------------------------------------------------------------
// ps2_mouse_packet
//
// Receive-only PS/2 mouse front end. The raw PS/2 clock and data lines are
// synchronised into the Clk domain, the clock is glitch-filtered, and 11-bit
// frames (start, 8 data LSB-first, odd parity, stop) are deserialised. Valid
// bytes are assembled into standard 3-byte stream-mode packets, which are
// presented as signed X/Y deltas plus button levels. This block never drives
// the PS/2 bus.
//
// Ports
//   Clk        in   system clock
//   Reset      in   asynchronous, active-high reset
//   PS2_CLK    in   raw PS/2 clock (asynchronous)
//   PS2_DAT    in   raw PS/2 data (asynchronous)
//   dx         out  9-bit signed X delta {Xsign, byte1}
//   dy         out  9-bit signed Y delta {Ysign, byte2}, up positive
//   m1,m2,m3   out  left / right / middle button levels
//   new_data   out  one-cycle pulse when dx/dy/m* take a new packet
//   frame_err  out  one-cycle pulse on parity, stop, sync error or timeout
// ---------------------------------------------------------------------------
module ps2_mouse_packet #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       m1,
    output logic       m2,
    output logic       m3,
    output logic       new_data,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_in;
    logic                   dat_in;

    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          change_done;
    logic          fall;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [1:0]    pkt_idx;
    logic [7:0]    byte0;
    logic [7:0]    byte1;

    logic [TW-1:0] to_cnt;
    logic          active;
    logic          timeout;
    logic          stop_ok;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a
    // phantom falling edge right after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync[0] <= PS2_CLK;
            dat_sync[0] <= PS2_DAT;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i] <= clk_sync[i-1];
                dat_sync[i] <= dat_sync[i-1];
            end
        end
    end

    assign clk_in = clk_sync[SYNC_STAGES-1];
    assign dat_in = dat_sync[SYNC_STAGES-1];

    // The filtered clock only flips once the synchronised clock has
    // disagreed with it for FILTER_LEN consecutive samples; any shorter
    // excursion restarts the count.
    assign change_done = (clk_in != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall        = change_done && clk_filt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_in == clk_filt) begin
            filt_cnt <= '0;
        end else if (change_done) begin
            clk_filt <= clk_in;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // The watchdog runs whenever a frame or a packet is in progress. A fall
    // in the same cycle as expiry suppresses the timeout, so a valid stop
    // bit always wins the race.
    assign active  = (state != ST_IDLE) || (pkt_idx != 2'd0);
    assign timeout = active && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt <= '0;
        end else if (fall || !active || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Odd parity over data plus parity bit means the XOR of all nine is 1.
    assign stop_ok = dat_in && (^{shift, parity_bit});

    // Bit FSM and packet assembler. Outputs are registered from the stop
    // cycle of byte2, so new_data and the new values appear one Clk later.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            pkt_idx    <= 2'd0;
            byte0      <= 8'h00;
            byte1      <= 8'h00;
            dx         <= 9'h000;
            dy         <= 9'h000;
            m1         <= 1'b0;
            m2         <= 1'b0;
            m3         <= 1'b0;
            new_data   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            new_data  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {dat_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_bit <= dat_in;
                        state      <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (stop_ok) begin
                            case (pkt_idx)
                                2'd0: begin
                                    // Bit 3 of byte0 is always set; a clear
                                    // bit means we are out of step, so hold
                                    // at idx0 until an aligned byte arrives.
                                    if (shift[3]) begin
                                        byte0   <= shift;
                                        pkt_idx <= 2'd1;
                                    end else begin
                                        frame_err <= 1'b1;
                                    end
                                end
                                2'd1: begin
                                    byte1   <= shift;
                                    pkt_idx <= 2'd2;
                                end
                                2'd2: begin
                                    dx       <= byte0[6] ? 9'h000 : {byte0[4], byte1};
                                    dy       <= byte0[7] ? 9'h000 : {byte0[5], shift};
                                    m1       <= byte0[0];
                                    m2       <= byte0[1];
                                    m3       <= byte0[2];
                                    new_data <= 1'b1;
                                    pkt_idx  <= 2'd0;
                                end
                                default: begin
                                    pkt_idx <= 2'd0;
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                            pkt_idx   <= 2'd0;
                        end
                    end
                endcase
            end else if (timeout) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
                pkt_idx   <= 2'd0;
            end
        end
    end

endmodule
